// File: rtl/lcd_pkg.sv
// Shared types and widths for the LCD character path (arbiters, engine wrappers).
package lcd_pkg;

    localparam int ASCII_W = 7;
    localparam int COORD_W = 9;
    localparam int GRANT_W = 3;
    localparam int TMO_W   = 16;

    typedef enum logic {
        FONT_12X6 = 1'b0,
        FONT_16X8 = 1'b1
    } font_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    // Round-robin successor of a requester index, wrapping at num_req.
    function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] id,
                                                    input int num_req);
        return (int'(id) == num_req - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/lcd_char_arbiter_if.sv
// Link between a requester-side arbiter and the show_char drawing engine.
interface lcd_char_arbiter_if;
    import lcd_pkg::*;

    logic               show_char_flag;
    logic               show_char_done;
    logic [ASCII_W-1:0] ascii_num;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic               en_size;

    modport master (output show_char_flag, ascii_num, start_x, start_y, en_size,
                    input  show_char_done);
    modport slave  (input  show_char_flag, ascii_num, start_x, start_y, en_size,
                    output show_char_done);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap.
module rr_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               any
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = GRANT_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Shares one show_char engine among NUM_REQ requesters: round-robin grant, launch, wait, ack.
module lcd_char_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       init_done,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ASCII_W-1:0] req_ascii,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ-1:0]         req_size,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       err,
    output logic                       busy,
    output logic [GRANT_W-1:0]         grant_id,
    lcd_char_arbiter_if.master         eng
);

    localparam logic [TMO_W-1:0] TERM_CNT = TMO_W'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [TMO_W-1:0]     cnt_q, cnt_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 flag_q, flag_d;
    logic [ASCII_W-1:0]   ascii_q, ascii_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    font_t                size_q, size_d;

    logic [NUM_REQ-1:0]   win_oh;
    logic [GRANT_W-1:0]   win_idx;
    logic                 win_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (win_oh),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        ascii_d    = ascii_q;
        x_d        = x_q;
        y_d        = y_q;
        size_d     = size_q;
        flag_d     = 1'b0;
        ack_d      = '0;
        err_d      = 1'b0;

        // Losing init_done abandons any service silently; the requester is retried later.
        if (!init_done) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (|req) state_d = ARB;
                ARB: begin
                    if (win_any) begin
                        grant_id_d = win_idx;
                        grant_oh_d = win_oh;
                        ascii_d    = req_ascii[int'(win_idx)*ASCII_W +: ASCII_W];
                        x_d        = req_x[int'(win_idx)*COORD_W +: COORD_W];
                        y_d        = req_y[int'(win_idx)*COORD_W +: COORD_W];
                        size_d     = font_t'(req_size[win_idx]);
                        flag_d     = 1'b1;
                        state_d    = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LAUNCH: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (eng.show_char_done || cnt_d == TERM_CNT) begin
                        ack_d   = grant_oh_q;
                        err_d   = !eng.show_char_done;
                        ptr_d   = next_ptr(grant_id_q, NUM_REQ);
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            flag_q     <= 1'b0;
            ascii_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            size_q     <= FONT_12X6;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values together.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            flag_q     <= flag_d;
            ascii_q    <= ascii_d;
            x_q        <= x_d;
            y_q        <= y_d;
            size_q     <= size_d;
        end
    end

    assign ack                = ack_q;
    assign err                = err_q;
    assign busy               = busy_q;
    assign grant_id           = grant_id_q;
    assign eng.show_char_flag = flag_q;
    assign eng.ascii_num      = ascii_q;
    assign eng.start_x        = x_q;
    assign eng.start_y        = y_q;
    assign eng.en_size        = size_q;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
// Randomised bench for lcd_char_arbiter with a service-level reference model and directed corner cases.
module tb_lcd_char_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 24;

    logic                sys_clk   = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic                init_done = 1'b0;
    logic [NREQ-1:0]     req_r     = '0;
    logic [NREQ*7-1:0]   req_ascii = '0;
    logic [NREQ*9-1:0]   req_x     = '0;
    logic [NREQ*9-1:0]   req_y     = '0;
    logic [NREQ-1:0]     req_size  = '0;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic                busy;
    logic [2:0]          grant_id;

    lcd_char_arbiter_if eng_if ();

    lcd_char_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .init_done (init_done),
        .req       (req_r),
        .req_ascii (req_ascii),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_size  (req_size),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .grant_id  (grant_id),
        .eng       (eng_if)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {28'd0, ack, err, busy, grant_id, eng_if.show_char_flag, eng_if.ascii_num,
                eng_if.start_x, eng_if.start_y, eng_if.en_size};
    endfunction

    // ---------------- reference model: one service = arbitrate, launch, wait, ack ----------------
    logic [3:0] e_ack;
    logic       e_err, e_busy, e_flag, e_size;
    logic [2:0] e_gid;
    logic [6:0] e_ascii;
    logic [8:0] e_x, e_y;
    bit         m_active;
    int         m_age, m_ptr, m_gid;
    longint     m_cyc, m_launch;

    task automatic model_reset();
        e_ack = '0; e_err = 0; e_busy = 0; e_flag = 0; e_size = 0;
        e_gid = '0; e_ascii = '0; e_x = '0; e_y = '0;
        m_active = 0; m_age = 0; m_ptr = 0; m_gid = 0; m_cyc = 0; m_launch = 0;
    endtask

    task automatic model_step();
        int w;
        w = -1;
        e_flag = 0; e_ack = '0; e_err = 0;
        if (!init_done) begin
            m_active = 0; e_busy = 0;
        end else if (!m_active) begin
            if (req_r != 0) begin m_active = 1; m_age = 1; e_busy = 1; end
        end else if (m_age == 1) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req_r[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w < 0) begin
                m_active = 0; e_busy = 0;
            end else begin
                m_gid = w; e_gid = 3'(w);
                e_ascii = req_ascii[7*w +: 7]; e_x = req_x[9*w +: 9];
                e_y = req_y[9*w +: 9]; e_size = req_size[w];
                e_flag = 1; m_age = 2; m_launch = m_cyc + 1;
            end
        end else if (m_age == 2) begin
            m_age = 3;
        end else if (m_age == 3) begin
            // Ack follows done by one cycle, or lands exactly TO cycles after the launch cycle.
            if (eng_if.show_char_done || (m_cyc + 1 - m_launch == TO)) begin
                e_ack = 4'(1) << m_gid; e_err = !eng_if.show_char_done;
                m_ptr = (m_gid + 1) % NREQ; m_age = 4;
            end
        end else begin
            m_active = 0; e_busy = 0;
        end
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) model_reset();
            else model_step();
        end
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge sys_clk);
        if (cmp_en && sys_rst_n)
            check("cycle_outputs", dut_vec(),
                  {28'd0, e_ack, e_err, e_busy, e_gid, e_flag, e_ascii, e_x, e_y, e_size});
    end

    // ---------------- monitor ----------------
    longint tcyc = 0;
    int     n_flag = 0, n_ack = 0;
    longint flag_cyc = 0, ack_cyc = 0;
    logic [3:0] last_ack = '0;
    logic       last_err = 0;
    int     gq[$];
    int     xq[$];

    initial forever begin @(posedge sys_clk); tcyc++; end

    initial forever begin
        @(negedge sys_clk);
        if (eng_if.show_char_flag) begin
            n_flag++; flag_cyc = tcyc; gq.push_back(int'(grant_id)); xq.push_back(int'(eng_if.start_x));
        end
        if (ack != 0) begin
            n_ack++; ack_cyc = tcyc; last_ack = ack; last_err = err;
        end
    end

    // ---------------- engine model ----------------
    bit eng_rand = 0;
    int eng_delay = 0;
    bit stray_done = 0;
    initial begin
        int rem, r;
        bit d;
        rem = 0;
        eng_if.show_char_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            d = stray_done;
            if (eng_if.show_char_flag) begin
                if (eng_rand) begin
                    r = int'($urandom_range(0, 7));
                    rem = (r == 0) ? 0 : (r == 1) ? TO - 1 : int'($urandom_range(1, 30));
                end else begin
                    rem = eng_delay;
                end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) d = 1;
            end
            eng_if.show_char_done = d;
        end
    end

    // ---------------- requesters ----------------
    bit auto_req = 0, drop_en = 0, x_fixed = 1;
    int x_tab [NREQ] = '{8, 16, 32, 40};
    int gap [NREQ] = '{0, 0, 0, 0};

    task automatic new_payload(input int i);
        req_ascii[7*i +: 7] = 7'($urandom);
        req_x[9*i +: 9]     = x_fixed ? 9'(x_tab[i]) : 9'($urandom);
        req_y[9*i +: 9]     = 9'($urandom);
        req_size[i]         = 1'($urandom);
    endtask

    initial forever begin
        @(negedge sys_clk);
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                req_r[i] = 1'b0;
                gap[i]   = auto_req ? int'($urandom_range(1, 3)) : 0;
            end else if (req_r[i]) begin
                if (drop_en && $urandom_range(0, 99) == 0) begin
                    req_r[i] = 1'b0; gap[i] = int'($urandom_range(1, 4));
                end
            end else if (auto_req && gap[i] > 0) begin
                gap[i]--;
                if (gap[i] == 0) begin new_payload(i); req_r[i] = 1'b1; end
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic step();
        @(negedge sys_clk); #1;
    endtask

    task automatic wait_flag(input int budget, input string name);
        int s, k;
        s = n_flag; k = 0;
        while (n_flag == s && k < budget) begin step(); k++; end
        check(name, 64'(n_flag != s), 64'd1);
    endtask

    task automatic wait_ack(input int budget, input string name);
        int s, k;
        s = n_ack; k = 0;
        while (n_ack == s && k < budget) begin step(); k++; end
        check(name, 64'(n_ack != s), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((busy || req_r != 0) && k < budget) begin step(); k++; end
        check(name, 64'(busy || req_r != 0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence + random phase ----------------
    initial begin
        int s_ack, init_low;
        longint restore_cyc;
        req_ascii[6:0] = 7'd82; req_x[8:0] = 9'd72; req_y[8:0] = 9'd16; req_size[0] = 1'b1;
        repeat (3) step();
        check("reset_outputs", dut_vec(), 64'd0);
        sys_rst_n = 1'b1;
        cmp_en = 1;

        // 1: gated by init_done, then flag two cycles after it rises
        req_r = 4'b0001;
        repeat (100) step();
        check("t1_no_flag", 64'(n_flag), 64'd0);
        check("t1_busy_low", 64'(busy), 64'd0);
        eng_delay = 20;
        init_done = 1'b1;
        step();
        check("t1_arb_cycle", {62'd0, busy, eng_if.show_char_flag}, 64'b10);
        step();
        check("t1_flag_payload", {46'd0, eng_if.show_char_flag, eng_if.ascii_num, eng_if.start_x,
              eng_if.start_y, eng_if.en_size}, {46'd0, 1'b1, 7'd82, 9'd72, 9'd16, 1'b1});

        // 2: done 20 cycles after flag, ack one cycle later
        wait_ack(100, "t2_ack_seen");
        check("t2_latency", 64'(ack_cyc - flag_cyc), 64'd21);
        check("t2_ack", 64'(last_ack), 64'b0001);
        check("t2_err", 64'(last_err), 64'd0);
        repeat (6) step();
        check("t2_no_reflag", 64'(n_flag), 64'd1);
        check("t2_idle", 64'(busy), 64'd0);

        // 3: all requesting, strict rotation from pointer 0
        sys_rst_n = 1'b0; step(); sys_rst_n = 1'b1;
        gq.delete(); xq.delete();
        x_fixed = 1; auto_req = 1; eng_delay = 3;
        for (int i = 0; i < NREQ; i++) new_payload(i);
        req_r = 4'b1111;
        for (int k = 0; k < 400 && gq.size() < 6; k++) step();
        check("t3_grants_seen", 64'(gq.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < gq.size(); k++) begin
            check("t3_grant_id", 64'(gq[k]), 64'(k % NREQ));
            check("t3_start_x", 64'(xq[k]), 64'(x_tab[k % NREQ]));
        end
        auto_req = 0;
        wait_idle(300, "t3_drain");

        // 4: timeout, then a normal service
        eng_delay = 0;
        new_payload(2); req_r[2] = 1'b1;
        wait_ack(100, "t4_ack_seen");
        check("t4_timeout_latency", 64'(ack_cyc - flag_cyc), 64'(TO));
        check("t4_ack", 64'(last_ack), 64'b0100);
        check("t4_err", 64'(last_err), 64'd1);
        step();
        eng_delay = 5;
        new_payload(1); req_r[1] = 1'b1;
        wait_ack(100, "t4b_ack_seen");
        check("t4b_latency", 64'(ack_cyc - flag_cyc), 64'd6);
        check("t4b_err", 64'(last_err), 64'd0);

        // 5: done on the terminal-count cycle, then a stray done while idle
        step();
        eng_delay = TO - 1;
        new_payload(3); req_r[3] = 1'b1;
        wait_ack(100, "t5_ack_seen");
        check("t5_latency", 64'(ack_cyc - flag_cyc), 64'(TO));
        check("t5_err", 64'(last_err), 64'd0);
        check("t5_ack", 64'(last_ack), 64'b1000);
        wait_idle(20, "t5_idle");
        s_ack = n_ack;
        stray_done = 1; step(); stray_done = 0;
        repeat (5) step();
        check("t5_stray_no_ack", 64'(n_ack), 64'(s_ack));

        // 6: init_done lost in WAIT, then restored with the request still held
        eng_delay = 0;
        new_payload(0); req_r[0] = 1'b1;
        wait_flag(20, "t6_flag_seen");
        repeat (5) step();
        s_ack = n_ack;
        init_done = 1'b0;
        step();
        check("t6_abort", {56'd0, busy, eng_if.show_char_flag, ack, err}, 64'd0);
        repeat (4) step();
        check("t6_no_ack", 64'(n_ack), 64'(s_ack));
        eng_delay = 4;
        init_done = 1'b1;
        restore_cyc = tcyc;
        wait_flag(10, "t6_reflag_seen");
        check("t6_reflag_latency", 64'(flag_cyc - restore_cyc), 64'd2);
        check("t6_regrant", 64'(grant_id), 64'd0);
        wait_ack(50, "t6_ack_seen");
        check("t6_ack", {59'd0, last_ack, last_err}, {59'd0, 4'b0001, 1'b0});

        // 7: random traffic, engine timing, init_done drops and stray done pulses
        x_fixed = 0; eng_rand = 1; drop_en = 1; auto_req = 1; init_low = 0;
        for (int i = 0; i < NREQ; i++) gap[i] = int'($urandom_range(1, 4));
        for (int c = 0; c < 3000; c++) begin
            step();
            if (init_low > 0) begin
                init_low--;
                if (init_low == 0) init_done = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                init_done = 1'b0; init_low = int'($urandom_range(1, 6));
            end
            stray_done = ($urandom_range(0, 49) == 0);
        end
        auto_req = 0; drop_en = 0; stray_done = 0; init_done = 1'b1;
        eng_rand = 0; eng_delay = 3;
        wait_idle(400, "t7_drain");

        // 8: asynchronous reset in the middle of WAIT
        eng_delay = 0;
        new_payload(1); req_r[1] = 1'b1;
        wait_flag(20, "t8_flag_seen");
        repeat (3) step();
        sys_rst_n = 1'b0;
        #1;
        check("t8_async_reset", dut_vec(), 64'd0);
        step();
        eng_delay = 2;
        sys_rst_n = 1'b1;
        wait_ack(60, "t8_reserved");
        check("t8_ack", 64'(last_ack), 64'b0010);
        wait_idle(20, "t8_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
